// File: rtl/cache_line_refill.sv
// Miss-side line refill engine: latches the victim way on a miss, bursts the line from the back-end,
// writes data then tag memories and reports the fill to the replacement policy. Macro: CACHE_REFILL_FWD_EN.
module cache_line_refill #(
  parameter int unsigned N_WAYS     = 8,
  parameter int unsigned NWAY_W     = $clog2(N_WAYS),
  parameter int unsigned LINE_OFF_W = 7,
  parameter int unsigned WORD_OFF_W = 3,
  parameter int unsigned TAG_W      = 20,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             miss_req,
  input  logic [LINE_OFF_W-1:0]            miss_line_addr,
  input  logic [TAG_W-1:0]                 miss_tag,
  input  logic [NWAY_W-1:0]                way_select_bin,
`ifdef CACHE_REFILL_FWD_EN
  input  logic [WORD_OFF_W-1:0]            miss_word_off,
  output logic                             fwd_valid,
  output logic [DATA_W-1:0]                fwd_rdata,
`endif
  output logic                             miss_ack,
  output logic                             busy,
  output logic                             be_req,
  output logic [TAG_W+LINE_OFF_W-1:0]      be_addr,
  input  logic                             be_ack,
  input  logic                             be_rvalid,
  input  logic [DATA_W-1:0]                be_rdata,
  output logic [N_WAYS-1:0]                data_we,
  output logic [LINE_OFF_W+WORD_OFF_W-1:0] data_addr,
  output logic [DATA_W-1:0]                data_wdata,
  output logic [N_WAYS-1:0]                tag_we,
  output logic [LINE_OFF_W-1:0]            tag_addr,
  output logic [TAG_W-1:0]                 tag_wdata,
  output logic                             rp_write_en,
  output logic [N_WAYS-1:0]                rp_way_hit,
  output logic [LINE_OFF_W-1:0]            rp_line_addr
);

  localparam logic [WORD_OFF_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [WORD_OFF_W-1:0]   cnt, cnt_nxt;
  logic [NWAY_W-1:0]       way_q, way_nxt;
  logic [LINE_OFF_W-1:0]   line_q, line_nxt;
  logic [TAG_W-1:0]        tag_q, tag_nxt;
  logic [WORD_OFF_W-1:0]   word_q, word_nxt;
  logic [N_WAYS-1:0]       way_onehot;

  logic                    miss_ack_nxt;
  logic                    busy_nxt;
  logic                    be_req_nxt;
  logic [N_WAYS-1:0]       data_we_nxt;
  logic [DATA_W-1:0]       data_wdata_nxt;
  logic [N_WAYS-1:0]       tag_we_nxt;
  logic                    rp_write_en_nxt;
  logic [N_WAYS-1:0]       rp_way_hit_nxt;

`ifdef CACHE_REFILL_FWD_EN
  logic [WORD_OFF_W-1:0]   woff_q, woff_nxt;
  logic                    fwd_valid_nxt;
  logic [DATA_W-1:0]       fwd_rdata_nxt;
`endif

  assign way_onehot = N_WAYS'(1) << way_q;

  // Address outputs always reflect the latched miss.
  assign be_addr      = {tag_q, line_q};
  assign data_addr    = {line_q, word_q};
  assign tag_addr     = line_q;
  assign tag_wdata    = tag_q;
  assign rp_line_addr = line_q;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    way_nxt         = way_q;
    line_nxt        = line_q;
    tag_nxt         = tag_q;
    word_nxt        = word_q;
    data_we_nxt     = '0;
    data_wdata_nxt  = data_wdata;
    tag_we_nxt      = '0;
    rp_write_en_nxt = 1'b0;
    rp_way_hit_nxt  = '0;
    miss_ack_nxt    = 1'b0;
    be_req_nxt      = 1'b0;
    busy_nxt        = 1'b0;
`ifdef CACHE_REFILL_FWD_EN
    woff_nxt        = woff_q;
    fwd_valid_nxt   = 1'b0;
    fwd_rdata_nxt   = fwd_rdata;
`endif

    unique case (state)
      IDLE: begin
        if (miss_req) begin
          way_nxt   = way_select_bin;
          line_nxt  = miss_line_addr;
          tag_nxt   = miss_tag;
`ifdef CACHE_REFILL_FWD_EN
          woff_nxt  = miss_word_off;
`endif
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (be_ack) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
      end
      FILL: begin
        if (be_rvalid) begin
          data_we_nxt    = way_onehot;
          word_nxt       = cnt;
          data_wdata_nxt = be_rdata;
          cnt_nxt        = cnt + WORD_OFF_W'(1);
`ifdef CACHE_REFILL_FWD_EN
          if (cnt == woff_q) begin
            fwd_valid_nxt = 1'b1;
            fwd_rdata_nxt = be_rdata;
          end
`endif
          if (cnt == CNT_LAST) begin
            state_nxt = COMMIT;
          end
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    be_req_nxt = (state_nxt == REQ);
    busy_nxt   = (state_nxt != IDLE);
    if (state_nxt == COMMIT) begin
      tag_we_nxt      = way_onehot;
      rp_write_en_nxt = 1'b1;
      rp_way_hit_nxt  = way_onehot;
      miss_ack_nxt    = 1'b1;
    end
  end

  // State, latched miss and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      way_q       <= '0;
      line_q      <= '0;
      tag_q       <= '0;
      word_q      <= '0;
      miss_ack    <= 1'b0;
      busy        <= 1'b0;
      be_req      <= 1'b0;
      data_we     <= '0;
      data_wdata  <= '0;
      tag_we      <= '0;
      rp_write_en <= 1'b0;
      rp_way_hit  <= '0;
`ifdef CACHE_REFILL_FWD_EN
      woff_q      <= '0;
      fwd_valid   <= 1'b0;
      fwd_rdata   <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      way_q       <= way_nxt;
      line_q      <= line_nxt;
      tag_q       <= tag_nxt;
      word_q      <= word_nxt;
      miss_ack    <= miss_ack_nxt;
      busy        <= busy_nxt;
      be_req      <= be_req_nxt;
      data_we     <= data_we_nxt;
      data_wdata  <= data_wdata_nxt;
      tag_we      <= tag_we_nxt;
      rp_write_en <= rp_write_en_nxt;
      rp_way_hit  <= rp_way_hit_nxt;
`ifdef CACHE_REFILL_FWD_EN
      woff_q      <= woff_nxt;
      fwd_valid   <= fwd_valid_nxt;
      fwd_rdata   <= fwd_rdata_nxt;
`endif
    end
  end

endmodule

// File: doc/cache_line_refill.md
# cache_line_refill

Miss-side consumer of the replacement policy's victim choice. On a front-end miss it latches the victim way and line/tag, issues a line burst to the back-end, writes the returned words into the victim way's data memory, then writes tag/valid and reports the fill as a hit on `write_en`/`way_hit` so the policy state is updated. Sits between cache control, the replacement policy and the back-end read interface.

## Interface
- `N_WAYS`, 8, number of ways (power of 2, ≥2)
- `NWAY_W`, $clog2(N_WAYS), way index width
- `LINE_OFF_W`, 7, line index width
- `WORD_OFF_W`, 3, log2 words per line (≥1)
- `TAG_W`, 20, tag width
- `DATA_W`, 32, word width
- `clk`  in  1  clock; one clock domain
- `reset`  in  1  asynchronous, active-high
- `miss_req`  in  1  miss pending; held until `miss_ack`
- `miss_line_addr`  in  LINE_OFF_W  line index of miss
- `miss_tag`  in  TAG_W  tag of miss
- `way_select_bin`  in  NWAY_W  victim from replacement policy
- `miss_ack`  out  1  one-cycle pulse, line filled
- `busy`  out  1  high in any state except IDLE
- `be_req`  out  1  burst request
- `be_addr`  out  TAG_W+LINE_OFF_W  line address {tag, index}
- `be_ack`  in  1  burst accepted
- `be_rvalid`  in  1  data beat valid
- `be_rdata`  in  DATA_W  data beat
- `data_we`  out  N_WAYS  one-hot data memory write enable
- `data_addr`  out  LINE_OFF_W+WORD_OFF_W  {index, word}
- `data_wdata`  out  DATA_W  word to write
- `tag_we`  out  N_WAYS  one-hot tag+valid write enable
- `tag_addr`  out  LINE_OFF_W  line index
- `tag_wdata`  out  TAG_W  tag to write
- `rp_write_en`  out  1  replacement policy update strobe
- `rp_way_hit`  out  N_WAYS  one-hot filled way
- `rp_line_addr`  out  LINE_OFF_W  line index for policy update

## Operation
- States: IDLE, REQ, FILL, COMMIT.
- IDLE: `miss_req`=1 → latch `miss_line_addr`, `miss_tag`, `way_select_bin`; go REQ.
- REQ: `be_req`=1, `be_addr`={latched tag, index}; stay until `be_ack`=1, then FILL, beat counter cnt=0.
- FILL: each `be_rvalid` writes word cnt; cnt increments. Beat with cnt=2^WORD_OFF_W−1 → COMMIT.
- COMMIT (one cycle): `tag_we`=one-hot(way), `tag_wdata`=latched tag; `rp_write_en`=1, `rp_way_hit`=one-hot(way); `miss_ack`=1; → IDLE.
- `tag_addr`, `rp_line_addr` and upper `data_addr` bits always show latched index.
- `be_rvalid` outside FILL ignored. Back-end returns exactly 2^WORD_OFF_W beats; first beat no earlier than cycle after `be_ack`.
- `way_select_bin` and inputs ignored after latch; changes mid-fill have no effect.

## Timing
- Reset: state IDLE, cnt 0, all outputs 0 (latched regs 0). Reset mid-fill aborts: no tag write, no policy update, line stays invalid.
- Data path registered: beat at cycle t → `data_we`/`data_addr`/`data_wdata` at t+1.
- Last beat at t → COMMIT at t+1; last data write, tag write, policy update and `miss_ack` all in that cycle.
- Minimum miss latency: request cycle 0 (IDLE latch) → REQ cycle 1 → ack at 1 → beats 2..2^WORD_OFF_W+1 → `miss_ack` at 2^WORD_OFF_W+2.
- Requester drops `miss_req` at the edge ending the `miss_ack` cycle; `miss_req` high in the following IDLE cycle is a new miss.
- cnt is WORD_OFF_W bits, wraps to 0 on COMMIT.

## Configuration
- `CACHE_REFILL_FWD_EN` defined: adds `miss_word_off` in WORD_OFF_W (latched with the miss), `fwd_valid` out 1, `fwd_rdata` out DATA_W. `fwd_valid` pulses for one cycle, aligned with the data write of word cnt==`miss_word_off`, carrying that word (early restart). Reset 0.
- Undefined: those ports and their logic absent; front end rereads after `miss_ack`.

## Test plan
- N_WAYS=4, WORD_OFF_W=2: miss index 5, tag 0xABCDE, way 2, `be_ack` immediate, 4 back-to-back beats 0x11..0x44 → `data_we`=0100 at addrs 20..23 with 0x11..0x44, COMMIT `tag_we`=0100, `rp_way_hit`=0100, `miss_ack` 6 cycles after request.
- Gapped beats (1 idle cycle between each), `be_ack` delayed 3 cycles → `be_req` held 4 cycles; writes only on valid beats; one `miss_ack`.
- `be_rvalid` pulsed during REQ and IDLE → no `data_we`.
- Reset asserted after 2nd beat → all outputs 0 immediately, no `tag_we`/`rp_write_en`; next miss completes normally.
- `way_select_bin` changed 1→3 mid-fill → all writes stay on way 1.
- With `CACHE_REFILL_FWD_EN`, `miss_word_off`=2 → single `fwd_valid` with 3rd beat's data, same cycle as its `data_we`.
